mdio_master_gen2: RTL and testbench
===================================

// Module: mdio_master_gen2
// PURPOSE
//  Parametrised IEEE 802.3 MDIO management master: next generation of the single-mode serialiser.
//  Adds Clause 22 and Clause 45 framing, a programmable MDC divider and a configurable preamble.
//  Sits between the register-access logic and the PHY management pins.
//  The caller supplies a 32-bit frame; the block shifts it out on MDC/MDIO and returns read data.
// PARAMETERS
//  DIV_HALF      1   clk cycles per MDC half-period (>=1); MDC period = 2*DIV_HALF clk
//  PREAMBLE_LEN  32  preamble '1' bits sent before ST; 0 = preamble suppression
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  rst         in   1   synchronous, active-high reset
//  MDIO_START  in   1   start request; accepted only when BUSY=0
//  T_DATA      in   32  frame {ST[31:30],OP[29:28],PHYAD/PRTAD[27:23],REGAD/DEVAD[22:18],TA[17:16],DATA[15:0]}
//  MDIO_IN     in   1   serial data from PHY (valid while MDIO_OE=0)
//  RD_DATA     out  16  last completed read data
//  DATA_RDY    out  1   one-cycle pulse: RD_DATA updated
//  BUSY        out  1   frame in progress
//  MDC         out  1   management clock
//  MDIO_OE     out  1   1 = master drives MDIO_OUT onto the pin
//  MDIO_OUT    out  1   serial data to PHY
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; frame register 0. rst mid-frame aborts next cycle with no DATA_RDY; RD_DATA cleared.
//  Accept: IDLE & MDIO_START=1 -> latch T_DATA, BUSY=1 next cycle. START while BUSY is ignored.
//  Read detect (from latched frame):
//  - ST=01 (C22): OP=10 is read; OP=01 is write.
//  - ST=00 (C45): OP[1]=1 (11 read, 10 post-read-inc) is read; OP 00 (address) and 01 (write) are writes.
//  - Other ST values: treated as write and sent verbatim.
//  Bit timing: each bit occupies 2*DIV_HALF clk.
//  - MDC=0 for the first DIV_HALF cycles, MDC=1 for the next DIV_HALF.
//  - MDIO_OUT/MDIO_OE change only at the start of the low phase.
//  - MDIO_IN is sampled on the clk edge where MDC goes 0->1.
//  FSM: IDLE -> PRE (PREAMBLE_LEN bits of 1, OE=1; skipped if 0) -> HDR (bits 31..18, OE=1) -> TA (2 bits) -> DATA (16 bits) -> IDLE.
//  - Write: TA drives T_DATA[17:16]; DATA drives T_DATA[15:0] MSB first; OE stays 1.
//  - Read: OE=0 and MDIO_OUT=0 from the first TA bit to frame end; the TA bits are not checked.
//  - Read: DATA samples 16 bits MSB first into a shift register.
//  Completion:
//  - Busy length = 2*DIV_HALF*(PREAMBLE_LEN+32) clk cycles.
//  - On the cycle after the last high phase: BUSY=0, MDC=0, OE=0.
//  - Read only, same cycle: RD_DATA <= shift reg, DATA_RDY=1 for exactly 1 cycle.
//  - A new MDIO_START may be accepted in that same cycle.
//  Counters:
//  - Phase counter width clog2(DIV_HALF)+1; wraps at DIV_HALF-1.
//  - Bit counter width clog2(PREAMBLE_LEN+32)+1, counts down to 0.
//  - No counter overflow is reachable.
//  RD_DATA holds its value through writes and aborted frames; it is cleared only by rst.
// STRUCTURE
//  mdio_pkg: ST_C22/ST_C45, OP codes, FSM state encodings, is_read() function.
//  Sub-module mdio_clk_gen: divider producing MDC, rise_tick and fall_tick.
//  - Parameter DIV_HALF; enabled by BUSY; held low when idle.
//  Top: FSM, frame shift register, read shift register, bit counter.
// TESTING
//  1 rst=1 for 3 cycles mid-anything -> MDC/OE/OUT/BUSY/DATA_RDY=0, RD_DATA=0.
//  2 C22 write, defaults, T_DATA=32'h5A5AFF01:
//    -> 32 ones then 0x5A5AFF01 MSB first; OE=1 for 128 clk; no DATA_RDY.
//  3 C22 read, T_DATA=32'h6A5A0000, PHY model drives 16'h8FF1:
//    -> OE falls at the 47th bit; DATA_RDY pulse at cycle 128; RD_DATA=16'h8FF1.
//  4 C45 read, T_DATA=32'h3A5A0000, PHY returns 16'hBEEF:
//    -> RD_DATA=16'hBEEF; a following C45 address frame (ST=00,OP=00) keeps OE=1 and RD_DATA unchanged.
//  5 MDIO_START re-pulsed mid-frame -> ignored, frame length unchanged.
//    Then rst during HDR bit 10 -> IDLE next cycle; a new read completes correctly.
//  6 PREAMBLE_LEN=0, DIV_HALF=3, write 32'h9A5AFF01 -> MDC period 6 clk; BUSY exactly 192 cycles.

Source files
------------

// File: rtl/mdio_pkg.sv
// MDIO framing constants, FSM state encoding and the read-detect rule
// shared by the management master and its sub-blocks.
package mdio_pkg;

    localparam logic [1:0] ST_C22         = 2'b01;
    localparam logic [1:0] ST_C45         = 2'b00;
    localparam logic [1:0] OP_C22_READ    = 2'b10;
    localparam logic [1:0] OP_C45_PRD_INC = 2'b10;
    localparam logic [1:0] OP_C45_READ    = 2'b11;
    localparam int         FRAME_BITS     = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4
    } mdio_state_e;

    // Unknown ST codes are sent verbatim as writes.
    function automatic logic is_read(input logic [1:0] st, input logic [1:0] op);
        logic rd_s;
        case (st)
            ST_C22:  rd_s = (op == OP_C22_READ);
            ST_C45:  rd_s = (op == OP_C45_READ) || (op == OP_C45_PRD_INC);
            default: rd_s = 1'b0;
        endcase
        return rd_s;
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: DIV_HALF clk cycles low then DIV_HALF high per bit, with
// strobes on the cycle before each MDC edge. Parked low while disabled.
module mdio_clk_gen #(
    parameter int DIV_HALF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic mdc,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int            PW      = $clog2(DIV_HALF) + 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DIV_HALF - 1);
    localparam logic [PW-1:0] PH_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PH_ONE  = PW'(1'b1);

    logic [PW-1:0] ph_r;
    logic          mdc_r;
    logic          wrap_s;

    // Half-period terminal count and edge strobes
    always_comb begin
        wrap_s    = en && (ph_r == PH_LAST);
        rise_tick = wrap_s && !mdc_r;
        fall_tick = wrap_s && mdc_r;
    end

    // Phase counter and MDC toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_r  <= PH_ZERO;
            mdc_r <= 1'b0;
        end else if (!en) begin
            ph_r  <= PH_ZERO;
            mdc_r <= 1'b0;
        end else if (wrap_s) begin
            ph_r  <= PH_ZERO;
            mdc_r <= !mdc_r;
        end else begin
            ph_r  <= ph_r + PH_ONE;
        end
    end

    assign mdc = mdc_r;

endmodule

// File: rtl/mdio_master_gen2.sv
// MDIO management master: serialises a Clause 22/45 frame behind a
// configurable preamble and captures the 16-bit read data.
module mdio_master_gen2
    import mdio_pkg::*;
#(
    parameter int DIV_HALF     = 1,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        BUSY,
    output logic        MDC,
    output logic        MDIO_OE,
    output logic        MDIO_OUT
);

    // Bit counter runs down across the whole frame; values below 32 index T_DATA directly.
    localparam int            BW          = $clog2(PREAMBLE_LEN + FRAME_BITS) + 1;
    localparam logic [BW-1:0] CNT_START   = BW'(PREAMBLE_LEN + FRAME_BITS - 1);
    localparam logic [BW-1:0] CNT_PRE_END = BW'(FRAME_BITS);
    localparam logic [BW-1:0] CNT_HDR_END = BW'(6'd18);
    localparam logic [BW-1:0] CNT_TA_END  = BW'(6'd16);
    localparam logic [BW-1:0] CNT_ZERO    = {BW{1'b0}};
    localparam logic [BW-1:0] CNT_ONE     = BW'(1'b1);

    mdio_state_e   state_r, state_nxt_s;
    logic [BW-1:0] bit_cnt_r, cnt_nxt_s;
    logic [31:0]   frame_r, frame_src_s;
    logic          rd_r, rd_src_s;
    logic [15:0]   shift_r, rd_data_r;
    logic          data_rdy_r, busy_r, mdio_oe_r, mdio_out_r;
    logic          out_nxt_s, oe_nxt_s;
    logic          accept_s, last_s, load_s;
    logic          mdc_s, rise_tick_s, fall_tick_s;

    mdio_clk_gen #(
        .DIV_HALF (DIV_HALF)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (busy_r),
        .mdc       (mdc_s),
        .rise_tick (rise_tick_s),
        .fall_tick (fall_tick_s)
    );

    // Frame-level strobes
    always_comb begin
        accept_s = (state_r == S_IDLE) && MDIO_START;
        last_s   = fall_tick_s && (state_r == S_DATA) && (bit_cnt_r == CNT_ZERO);
        load_s   = accept_s || fall_tick_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: phases advance only when a bit ends
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (MDIO_START) begin
                    state_nxt_s = (PREAMBLE_LEN > 0) ? S_PRE : S_HDR;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_PRE: begin
                if (fall_tick_s && (bit_cnt_r == CNT_PRE_END)) state_nxt_s = S_HDR;
                else state_nxt_s = S_PRE;
            end
            S_HDR: begin
                if (fall_tick_s && (bit_cnt_r == CNT_HDR_END)) state_nxt_s = S_TA;
                else state_nxt_s = S_HDR;
            end
            S_TA: begin
                if (fall_tick_s && (bit_cnt_r == CNT_TA_END)) state_nxt_s = S_DATA;
                else state_nxt_s = S_TA;
            end
            S_DATA: begin
                if (last_s) state_nxt_s = S_IDLE;
                else state_nxt_s = S_DATA;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output logic: next pin values for the bit that starts on this edge
    always_comb begin
        frame_src_s = frame_r;
        rd_src_s    = rd_r;
        cnt_nxt_s   = bit_cnt_r;
        out_nxt_s   = mdio_out_r;
        oe_nxt_s    = mdio_oe_r;
        if (accept_s) begin
            frame_src_s = T_DATA;
            rd_src_s    = is_read(T_DATA[31:30], T_DATA[29:28]);
            cnt_nxt_s   = CNT_START;
        end else if (fall_tick_s && (bit_cnt_r != CNT_ZERO)) begin
            cnt_nxt_s   = bit_cnt_r - CNT_ONE;
        end else begin
            cnt_nxt_s   = bit_cnt_r;
        end
        if (load_s) begin
            case (state_nxt_s)
                S_PRE: begin
                    out_nxt_s = 1'b1;
                    oe_nxt_s  = 1'b1;
                end
                S_HDR: begin
                    out_nxt_s = frame_src_s[cnt_nxt_s[4:0]];
                    oe_nxt_s  = 1'b1;
                end
                S_TA, S_DATA: begin
                    if (rd_src_s) begin
                        out_nxt_s = 1'b0;
                        oe_nxt_s  = 1'b0;
                    end else begin
                        out_nxt_s = frame_src_s[cnt_nxt_s[4:0]];
                        oe_nxt_s  = 1'b1;
                    end
                end
                default: begin
                    out_nxt_s = 1'b0;
                    oe_nxt_s  = 1'b0;
                end
            endcase
        end else begin
            out_nxt_s = mdio_out_r;
            oe_nxt_s  = mdio_oe_r;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r  <= CNT_ZERO;
            frame_r    <= 32'h0000_0000;
            rd_r       <= 1'b0;
            shift_r    <= 16'h0000;
            rd_data_r  <= 16'h0000;
            data_rdy_r <= 1'b0;
            busy_r     <= 1'b0;
            mdio_oe_r  <= 1'b0;
            mdio_out_r <= 1'b0;
        end else begin
            bit_cnt_r  <= cnt_nxt_s;
            mdio_out_r <= out_nxt_s;
            mdio_oe_r  <= oe_nxt_s;
            data_rdy_r <= last_s && rd_r;
            if (accept_s) begin
                frame_r <= T_DATA;
                rd_r    <= rd_src_s;
                busy_r  <= 1'b1;
            end else if (last_s) begin
                busy_r  <= 1'b0;
            end
            if (rise_tick_s && (state_r == S_DATA) && rd_r) begin
                shift_r <= {shift_r[14:0], MDIO_IN};
            end
            if (last_s && rd_r) begin
                rd_data_r <= shift_r;
            end
        end
    end

    assign RD_DATA  = rd_data_r;
    assign DATA_RDY = data_rdy_r;
    assign BUSY     = busy_r;
    assign MDC      = mdc_s;
    assign MDIO_OE  = mdio_oe_r;
    assign MDIO_OUT = mdio_out_r;

endmodule

// File: tb/tb_mdio_master_gen2.sv
// Scoreboard bench: lane 0 uses default parameters, lane 1 uses
// DIV_HALF=3 with preamble suppression; each lane has its own PHY model.
module tb_mdio_master_gen2;

    localparam int NL = 2;

    typedef struct {
        bit [63:0] out;
        bit [63:0] oe;
        int        nbits;
        int        busy_len;
        bit        rd;
        bit [15:0] phy;
        bit [15:0] rdata;
    } exp_t;

    bit          clk = 1'b0;
    bit          rst = 1'b1;
    logic        start_a    [NL];
    logic [31:0] tdata_a    [NL];
    logic        mdio_in_a  [NL];
    logic [15:0] rd_data_a  [NL];
    logic        data_rdy_a [NL];
    logic        busy_a     [NL];
    logic        mdc_a      [NL];
    logic        oe_a       [NL];
    logic        out_a      [NL];

    exp_t      exp_q [NL][$];
    bit [15:0] last_rd [NL];

    bit        rst_p = 1'b0;
    bit        busy_p [NL];
    bit        mdc_p [NL];
    bit        bad_stream [NL];
    bit        bad_run [NL];
    bit        stray_rdy [NL];
    bit        rdy_pend [NL];
    int        rise_cnt [NL];
    int        blen [NL];
    int        hi_run [NL];
    int        bad_pos [NL];

    int n_pass = 0;
    int n_chk  = 0;
    int n_tmo  = 0;

    always #5 clk = ~clk;

    mdio_master_gen2 u_dut0 (
        .clk(clk), .rst(rst), .MDIO_START(start_a[0]), .T_DATA(tdata_a[0]),
        .MDIO_IN(mdio_in_a[0]), .RD_DATA(rd_data_a[0]), .DATA_RDY(data_rdy_a[0]),
        .BUSY(busy_a[0]), .MDC(mdc_a[0]), .MDIO_OE(oe_a[0]), .MDIO_OUT(out_a[0])
    );

    mdio_master_gen2 #(.DIV_HALF(3), .PREAMBLE_LEN(0)) u_dut1 (
        .clk(clk), .rst(rst), .MDIO_START(start_a[1]), .T_DATA(tdata_a[1]),
        .MDIO_IN(mdio_in_a[1]), .RD_DATA(rd_data_a[1]), .DATA_RDY(data_rdy_a[1]),
        .BUSY(busy_a[1]), .MDC(mdc_a[1]), .MDIO_OE(oe_a[1]), .MDIO_OUT(out_a[1])
    );

    function automatic int dh_of(input int l);
        return (l == 0) ? 1 : 3;
    endfunction

    function automatic int p_of(input int l);
        return (l == 0) ? 32 : 0;
    endfunction

    function automatic bit model_read(input bit [31:0] t);
        if (t[31:30] == 2'b01) return t[29:28] == 2'b10;
        if (t[31:30] == 2'b00) return t[29:28] == 2'b10 || t[29:28] == 2'b11;
        return 1'b0;
    endfunction

    // Expected pin sequence: preamble ones, then the frame MSB first; reads release from TA on.
    function automatic exp_t build(input int l, input bit [31:0] t, input bit [15:0] phy);
        exp_t e;
        int   p = p_of(l);
        e.out = 64'd0;
        e.oe = 64'd0;
        e.nbits = p + 32;
        e.busy_len = 2 * dh_of(l) * e.nbits;
        e.phy = phy;
        e.rd = model_read(t);
        for (int i = 0; i < p; i++) begin
            e.out[i] = 1'b1;
            e.oe[i] = 1'b1;
        end
        for (int j = 0; j < 32; j++) begin
            if (e.rd && j >= 14) begin
                e.out[p + j] = 1'b0;
                e.oe[p + j] = 1'b0;
            end else begin
                e.out[p + j] = t[31 - j];
                e.oe[p + j] = 1'b1;
            end
        end
        if (e.rd) last_rd[l] = phy;
        e.rdata = last_rd[l];
        return e;
    endfunction

    function automatic void chk(input string name, input int l, input logic [31:0] act,
                                input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s lane%0d: got %0h expected %0h", name, l, act, expv);
    endfunction

    task automatic tmo(input string name);
        n_tmo++;
        $display("FAIL timeout %s", name);
    endtask

    // Monitor, scoreboard and PHY model, all on the falling clk edge
    always @(negedge clk) begin
        exp_t e;
        int   idx;
        for (int l = 0; l < NL; l++) begin
            if (rst_p) begin
                chk("rst_outputs", l, 32'({busy_a[l], mdc_a[l], oe_a[l], out_a[l], data_rdy_a[l]}), 32'd0);
                chk("rst_rd_data", l, 32'(rd_data_a[l]), 32'd0);
                busy_p[l] = 1'b0;
                mdc_p[l] = 1'b0;
                rdy_pend[l] = 1'b0;
            end else begin
                if (rdy_pend[l]) begin
                    chk("rdy_width", l, 32'(data_rdy_a[l]), 32'd0);
                    rdy_pend[l] = 1'b0;
                end
                if (busy_a[l] === 1'b1 && !busy_p[l]) begin
                    rise_cnt[l] = 0; blen[l] = 0; hi_run[l] = 0; bad_pos[l] = -1;
                    bad_stream[l] = 1'b0; bad_run[l] = 1'b0; stray_rdy[l] = 1'b0;
                end
                if (busy_a[l] === 1'b1) begin
                    blen[l]++;
                    if (mdc_a[l] && !mdc_p[l]) rise_cnt[l]++;
                    if (mdc_a[l]) hi_run[l]++;
                    else if (mdc_p[l]) begin
                        if (hi_run[l] != dh_of(l)) bad_run[l] = 1'b1;
                        hi_run[l] = 0;
                    end
                    if (data_rdy_a[l] !== 1'b0) stray_rdy[l] = 1'b1;
                    if (exp_q[l].size() > 0) begin
                        e = exp_q[l][0];
                        idx = mdc_a[l] ? rise_cnt[l] - 1 : rise_cnt[l];
                        if (idx < 0 || idx >= e.nbits || out_a[l] !== e.out[idx] || oe_a[l] !== e.oe[idx]) begin
                            if (!bad_stream[l]) bad_pos[l] = idx;
                            bad_stream[l] = 1'b1;
                        end
                    end
                end else if (busy_p[l]) begin
                    if (exp_q[l].size() > 0) begin
                        e = exp_q[l].pop_front();
                        chk("bit_stream", l, 32'(bad_pos[l]), 32'hFFFF_FFFF);
                        chk("bit_count", l, 32'(rise_cnt[l]), 32'(e.nbits));
                        chk("busy_len", l, 32'(blen[l]), 32'(e.busy_len));
                        chk("mdc_high_run", l, 32'(bad_run[l] || hi_run[l] != dh_of(l)), 32'd0);
                        chk("end_mdc_oe", l, 32'({mdc_a[l], oe_a[l]}), 32'd0);
                        chk("stray_rdy", l, 32'(stray_rdy[l]), 32'd0);
                        chk("data_rdy", l, 32'(data_rdy_a[l]), 32'(e.rd));
                        chk("rd_data", l, 32'(rd_data_a[l]), 32'(e.rdata));
                        rdy_pend[l] = 1'b1;
                    end else begin
                        chk("unexpected_frame", l, 32'd1, 32'd0);
                    end
                end
                busy_p[l] = (busy_a[l] === 1'b1);
                mdc_p[l] = (mdc_a[l] === 1'b1);
            end
            mdio_in_a[l] = 1'($urandom);
            if (busy_a[l] === 1'b1 && exp_q[l].size() > 0) begin
                e = exp_q[l][0];
                if (e.rd && rise_cnt[l] >= e.nbits - 16 && rise_cnt[l] < e.nbits)
                    mdio_in_a[l] = e.phy[e.nbits - 1 - rise_cnt[l]];
            end
        end
        rst_p = rst;
    end

    task automatic send(input int l, input bit [31:0] t, input bit [15:0] phy, input bit push);
        int w = 0;
        while (busy_a[l] !== 1'b0 && w < 3000) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 3000) tmo("send");
        if (push) exp_q[l].push_back(build(l, t, phy));
        start_a[l] = 1'b1;
        tdata_a[l] = t;
        @(posedge clk); #1;
        start_a[l] = 1'b0;
        tdata_a[l] = $urandom;
    endtask

    task automatic wait_idle(input int l);
        int w = 0;
        while ((busy_a[l] !== 1'b0 || exp_q[l].size() != 0) && w < 3000) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 3000) tmo("wait_idle");
        @(posedge clk); #1;
    endtask

    task automatic rand_frames(input int l, input int n);
        bit [31:0] t;
        for (int k = 0; k < n; k++) begin
            t = $urandom;
            case ($urandom_range(0, 3))
                0: t[31:30] = 2'b01;
                1: t[31:30] = 2'b00;
                2: t[31:29] = 3'b011;
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) begin
                wait_idle(l);
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            send(l, t, 16'($urandom), 1'b1);
        end
    endtask

    initial begin
        for (int l = 0; l < NL; l++) begin
            start_a[l] = 1'b0;
            tdata_a[l] = 32'd0;
            last_rd[l] = 16'd0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        send(0, 32'h5A5AFF01, 16'($urandom), 1'b1);
        send(0, 32'h6A5A0000, 16'h8FF1, 1'b1);
        send(0, 32'h3A5A0000, 16'hBEEF, 1'b1);
        send(0, 32'h0A5A1234, 16'($urandom), 1'b1);
        wait_idle(0);

        // START re-pulsed with a different frame while busy must be ignored
        send(0, 32'h6B5A0000, 16'h1234, 1'b1);
        repeat (40) @(posedge clk);
        #1 start_a[0] = 1'b1;
        tdata_a[0] = 32'h5FFF_FFFF;
        @(posedge clk); #1 start_a[0] = 1'b0;
        wait_idle(0);

        // Abort a read during header bit 10, then a clean read
        send(0, 32'h6A5A0000, 16'h0F0F, 1'b0);
        repeat (82) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int l = 0; l < NL; l++) last_rd[l] = 16'd0;
        @(posedge clk); #1;
        send(0, 32'h6A5A0000, 16'hC3A5, 1'b1);
        rand_frames(0, 18);
        wait_idle(0);

        send(1, 32'h9A5AFF01, 16'($urandom), 1'b1);
        send(1, 32'h6A5A0000, 16'h8FF1, 1'b1);
        rand_frames(1, 6);
        wait_idle(1);
        wait_idle(0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk + n_tmo);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_chk + n_tmo);
        $fatal(1, "watchdog");
    end

endmodule
